bp_be_fe_cmd_issuer: RTL

Back-end producer of the FE command stream: it arbitrates BE events, formats them as bp_fe_cmd_s, buffers them in a small FIFO, and presents them to the front-end over fe_cmd_o/fe_cmd_v_o/fe_cmd_yumi_i.
Non-attaboy commands are lossless and back-pressured per source. Attaboys are best-effort hints and are dropped when they cannot be queued.
It also exports a pending flag that BE issue logic uses to stall while FE redirects are outstanding.

---
 rtl/bp_be_fe_cmd_issuer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bp_be_fe_cmd_issuer.sv
// Back-end FE command issuer: arbitrates BE events into fe_cmd packets and queues them
// in a small FIFO toward the front-end. Attaboys are best-effort and dropped when they cannot queue.
module bp_be_fe_cmd_issuer #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int fifo_els_p                  = 4,
  localparam int opcode_width_lp  = 4,
  localparam int subop_width_lp   = 3,
  localparam int reason_width_lp  = 2,
  localparam int priv_width_lp    = 2,
  localparam int operand_width_lp = priv_width_lp + 1 + subop_width_lp + reason_width_lp
                                    + branch_metadata_fwd_width_p,
  localparam int fe_cmd_width_lp  = operand_width_lp + vaddr_width_p + opcode_width_lp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   state_reset_v_i,
  input  logic                                   redirect_v_i,
  input  logic [subop_width_lp-1:0]              redirect_subop_i,
  input  logic [reason_width_lp-1:0]             redirect_reason_i,
  input  logic [branch_metadata_fwd_width_p-1:0] redirect_metadata_i,
  input  logic [vaddr_width_p-1:0]               npc_i,
  input  logic [priv_width_lp-1:0]               priv_i,
  input  logic                                   translation_en_i,
  input  logic                                   fill_v_i,
  input  logic [opcode_width_lp-1:0]             fill_opcode_i,
  input  logic [operand_width_lp-1:0]            fill_operands_i,
  input  logic                                   fence_v_i,
  input  logic                                   fence_itlb_i,
  input  logic                                   attaboy_v_i,
  input  logic [vaddr_width_p-1:0]               attaboy_pc_i,
  input  logic                                   attaboy_taken_i,
  input  logic [branch_metadata_fwd_width_p-1:0] attaboy_metadata_i,

  output logic                                   state_reset_yumi_o,
  output logic                                   redirect_yumi_o,
  output logic                                   fill_yumi_o,
  output logic                                   fence_yumi_o,

  output logic [fe_cmd_width_lp-1:0]             fe_cmd_o,
  output logic                                   fe_cmd_v_o,
  input  logic                                   fe_cmd_yumi_i,

  output logic                                   cmd_pending_o,
  output logic                                   attaboy_drop_o
);

  localparam logic [opcode_width_lp-1:0] e_op_state_reset     = 4'd0;
  localparam logic [opcode_width_lp-1:0] e_op_pc_redirection  = 4'd1;
  localparam logic [opcode_width_lp-1:0] e_op_icache_fence    = 4'd4;
  localparam logic [opcode_width_lp-1:0] e_op_attaboy         = 4'd5;
  localparam logic [opcode_width_lp-1:0] e_op_itlb_fence      = 4'd8;

  localparam logic [subop_width_lp-1:0]  e_subop_branch_mispredict = 3'd0;

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(fifo_els_p);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

  logic [ptr_w_lp:0]          wr_ptr_r, rd_ptr_r;
  logic [fe_cmd_width_lp-1:0] mem_r [fifo_els_p];
  logic [cnt_w_lp-1:0]        cnt_r, cnt_n;
  logic                       pending_r;

  logic full, empty, can_push;
  logic attaboy_push, cmd_push, push, pop;
  logic head_is_cmd;
  logic [fe_cmd_width_lp-1:0] push_pkt;
  logic [reason_width_lp-1:0] reason_g;

  // Wrap bit differs with equal index bits: the buffer has lapped the reader.
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[ptr_w_lp] != rd_ptr_r[ptr_w_lp])
              && (wr_ptr_r[ptr_w_lp-1:0] == rd_ptr_r[ptr_w_lp-1:0]);

  assign can_push = ~full & ~reset_i;

  assign state_reset_yumi_o = state_reset_v_i & can_push;
  assign redirect_yumi_o    = redirect_v_i & ~state_reset_v_i & can_push;
  assign fill_yumi_o        = fill_v_i & ~state_reset_v_i & ~redirect_v_i & can_push;
  assign fence_yumi_o       = fence_v_i & ~state_reset_v_i & ~redirect_v_i & ~fill_v_i & can_push;

  assign attaboy_push   = attaboy_v_i & ~(state_reset_v_i | redirect_v_i | fill_v_i | fence_v_i)
                        & can_push;
  assign attaboy_drop_o = attaboy_v_i & ~attaboy_push & ~reset_i;

  assign cmd_push = state_reset_yumi_o | redirect_yumi_o | fill_yumi_o | fence_yumi_o;
  assign push     = cmd_push | attaboy_push;
  assign pop      = fe_cmd_yumi_i & ~empty & ~reset_i;

  assign reason_g = (redirect_subop_i == e_subop_branch_mispredict) ? redirect_reason_i : '0;

  // Operand layout, msb first: priv | translation_en | subop | reason | metadata.
  always_comb begin
    push_pkt = '0;
    if (state_reset_v_i) begin
      push_pkt = {priv_i, translation_en_i, {subop_width_lp{1'b0}}, {reason_width_lp{1'b0}},
                  {branch_metadata_fwd_width_p{1'b0}}, npc_i, e_op_state_reset};
    end else if (redirect_v_i) begin
      push_pkt = {priv_i, translation_en_i, redirect_subop_i, reason_g,
                  redirect_metadata_i, npc_i, e_op_pc_redirection};
    end else if (fill_v_i) begin
      push_pkt = {fill_operands_i, npc_i, fill_opcode_i};
    end else if (fence_v_i) begin
      push_pkt = {{operand_width_lp{1'b0}}, npc_i,
                  (fence_itlb_i ? e_op_itlb_fence : e_op_icache_fence)};
    end else if (attaboy_v_i) begin
      push_pkt = {{(priv_width_lp + subop_width_lp + reason_width_lp){1'b0}}, attaboy_taken_i,
                  attaboy_metadata_i, attaboy_pc_i, e_op_attaboy};
    end
  end

  assign fe_cmd_o    = mem_r[rd_ptr_r[ptr_w_lp-1:0]];
  assign fe_cmd_v_o  = ~empty;
  assign head_is_cmd = (fe_cmd_o[opcode_width_lp-1:0] != e_op_attaboy);

  always_comb begin
    cnt_n = cnt_r;
    case ({cmd_push, pop & head_is_cmd})
      2'b10:   cnt_n = cnt_r + cnt_one_lp;
      2'b01:   cnt_n = cnt_r - cnt_one_lp;
      default: cnt_n = cnt_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      cnt_r     <= '0;
      pending_r <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      cnt_r     <= cnt_n;
      pending_r <= (cnt_n != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r[ptr_w_lp-1:0]] <= push_pkt;
  end

  assign cmd_pending_o = pending_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_cmd_yumi_i && empty));
      assert (!(cmd_push && !(pop && head_is_cmd) && cnt_r == cnt_max_lp));
      assert (!(pop && head_is_cmd && !cmd_push && cnt_r == '0));
    end
  end

endmodule
